// File: rtl/pixel_collector.sv
// Collects 4-bit results from row-interleaved solvers and serialises them onto one framebuffer
// write port. Define PIXEL_COLLECTOR_STATS_EN to build the stall_cycles counter.
module pixel_collector #(
  parameter int unsigned NUM_SOLVERS = 2,
  parameter int unsigned NUM_COLUMNS = 640,
  parameter int unsigned NUM_ROWS    = 480,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_SOLVERS-1:0]   solver_ready,
  input  logic [4*NUM_SOLVERS-1:0] solver_out,
  output logic                     wr_valid,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [3:0]               wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [31:0]              stall_cycles
);

  localparam int unsigned TOTAL = NUM_COLUMNS * NUM_ROWS;
  localparam int unsigned PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int unsigned COL_W = $clog2(NUM_COLUMNS + 1);
  localparam int unsigned PIX_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PIX_W-1:0]         pix_cnt_q;
  logic [NUM_SOLVERS-1:0]   slot_full_q;
  logic [3:0]               slot_data_q [NUM_SOLVERS];
  logic [ADDR_W-1:0]        slot_addr_q [NUM_SOLVERS];
  logic [ADDR_W-1:0]        addr_cnt_q  [NUM_SOLVERS];
  logic [COL_W-1:0]         col_q       [NUM_SOLVERS];

  logic                     handshake;
  logic                     last_pixel;
  logic                     load_out;
  logic                     grant_valid;
  logic [PTR_W-1:0]         grant_idx;
  logic [NUM_SOLVERS-1:0]   drain;

  assign handshake  = wr_valid & wr_ready;
  assign last_pixel = handshake && (pix_cnt_q == PIX_W'(TOTAL - 1));
  assign load_out   = (state_q == StRun) && (!wr_valid || handshake) && !last_pixel;

  // Round-robin pick: first full slot at or after the pointer.
  always_comb begin
    int unsigned      cand;
    logic [PTR_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_SOLVERS;
      cand_idx = PTR_W'(cand);
      if (!grant_valid && slot_full_q[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    drain = '0;
    for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
      drain[k] = load_out && grant_valid && (grant_idx == PTR_W'(k));
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start) begin
      state_q     <= reset ? StIdle : StRun;
      busy        <= !reset;
      rr_ptr_q    <= '0;
      pix_cnt_q   <= '0;
      slot_full_q <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
        slot_data_q[k] <= '0;
        slot_addr_q[k] <= '0;
        addr_cnt_q[k]  <= ADDR_W'(k * NUM_COLUMNS);
        col_q[k]       <= '0;
      end
    end else if (state_q == StRun) begin
      for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
        if (drain[k]) slot_full_q[k] <= 1'b0;
        if (solver_ready[k]) begin
          if (!slot_full_q[k] || drain[k]) begin
            slot_full_q[k] <= 1'b1;
            slot_data_q[k] <= solver_out[4*k +: 4];
            slot_addr_q[k] <= addr_cnt_q[k];
            // End of row jumps over the rows owned by the other solvers.
            if (col_q[k] < COL_W'(NUM_COLUMNS - 1)) begin
              addr_cnt_q[k] <= addr_cnt_q[k] + ADDR_W'(1);
              col_q[k]      <= col_q[k] + COL_W'(1);
            end else begin
              addr_cnt_q[k] <= addr_cnt_q[k] + ADDR_W'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);
              col_q[k]      <= '0;
            end
          end else begin
            overflow <= 1'b1;
          end
        end
      end

      if (handshake) pix_cnt_q <= pix_cnt_q + PIX_W'(1);

      if (last_pixel) begin
        state_q    <= StDone;
        busy       <= 1'b0;
        frame_done <= 1'b1;
        wr_valid   <= 1'b0;
      end else if (load_out) begin
        wr_valid <= grant_valid;
        if (grant_valid) begin
          wr_addr  <= slot_addr_q[grant_idx];
          wr_data  <= slot_data_q[grant_idx];
          rr_ptr_q <= (grant_idx == PTR_W'(NUM_SOLVERS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
      end
    end
  end

`ifdef PIXEL_COLLECTOR_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset || start) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && wr_valid && !wr_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pixel_collector.sv
// Randomised bench for pixel_collector against a queue/arithmetic reference model.
module tb_pixel_collector;

  localparam int N     = 2;
  localparam int C     = 4;
  localparam int R     = 4;
  localparam int AW    = 19;
  localparam int TOTAL = C * R;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  solver_ready;
  logic [4*N-1:0] solver_out;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_ready;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [31:0]   stall_cycles;

  always #5 clock = ~clock;

  pixel_collector #(
    .NUM_SOLVERS(N),
    .NUM_COLUMNS(C),
    .NUM_ROWS   (R),
    .ADDR_W     (AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .solver_ready(solver_ready),
    .solver_out  (solver_out),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one pending pixel per solver, addresses from row/column arithmetic.
  bit      m_run, m_done, m_valid, m_ovf;
  bit      m_full [N];
  int      m_saddr[N];
  int      m_sdata[N];
  int      m_ncap [N];
  int      m_addr, m_data, m_rr, m_pix;
  longint  m_stall;
  int      wlog[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pixel_addr(input int k, input int n);
    int row;
    row = k + (n / C) * N;
    return (row * C + (n % C)) & ((1 << AW) - 1);
  endfunction

  task automatic model_init(input bit run);
    m_run = run; m_done = 0; m_valid = 0; m_ovf = 0;
    m_addr = 0; m_data = 0; m_rr = 0; m_pix = 0; m_stall = 0;
    for (int k = 0; k < N; k++) begin
      m_full[k] = 0; m_ncap[k] = 0;
    end
  endtask

  task automatic model_step();
    bit hs, last, load;
    int g, ga, gd, idx;
    if (reset) begin
      model_init(0);
    end else if (start) begin
      model_init(1);
    end else if (m_run) begin
      hs   = m_valid && wr_ready;
      last = hs && (m_pix == TOTAL - 1);
      load = (!m_valid || hs) && !last;
      g = -1; ga = 0; gd = 0;
      for (int i = 0; i < N; i++) begin
        idx = (m_rr + i) % N;
        if (g < 0 && m_full[idx]) g = idx;
      end
      if (m_valid && !wr_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (load && g >= 0) begin
        ga = m_saddr[g]; gd = m_sdata[g]; m_full[g] = 0;
      end
      for (int k = 0; k < N; k++) begin
        if (solver_ready[k]) begin
          if (!m_full[k]) begin
            m_full[k]  = 1;
            m_saddr[k] = pixel_addr(k, m_ncap[k]);
            m_sdata[k] = int'(solver_out[4*k +: 4]);
            m_ncap[k]++;
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (hs) m_pix++;
      if (last) begin
        m_valid = 0; m_run = 0; m_done = 1;
      end else if (load) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_addr = ga; m_data = gd; m_rr = (g + 1) % N;
        end
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] rdy, input logic st);
    solver_ready = rdy;
    start        = st;
    for (int k = 0; k < N; k++) solver_out[4*k +: 4] = 4'($urandom);
    model_step();
    if (wr_valid && wr_ready) wlog.push_back(int'(wr_addr));
    @(posedge clock);
    #1;
    check_eq("wr_valid", wr_valid, m_valid);
    check_eq("wr_addr", wr_addr, m_addr);
    check_eq("wr_data", wr_data, m_data);
    check_eq("busy", busy, m_run);
    check_eq("frame_done", frame_done, m_done);
    check_eq("overflow", overflow, m_ovf);
`ifdef PIXEL_COLLECTOR_STATS_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
`else
    check_eq("stall_cycles", stall_cycles, 0);
`endif
    solver_ready = '0;
    start        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; solver_ready = '0; solver_out = '0; wr_ready = 1'b1;
    idle(3);
    reset = 1'b0;

    // First pixel latency and solver 1 base address.
    cyc('0, 1'b1);
    cyc(2'b01, 1'b0);
    idle(2);
    cyc(2'b10, 1'b0);
    idle(3);

    // Column wrap skips the other solver's row.
    cyc('0, 1'b1);
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      cyc(2'b01, 1'b0);
      cyc('0, 1'b0);
    end
    idle(3);
    check_eq("wrap_count", wlog.size(), 5);
    if (wlog.size() == 5) begin
      check_eq("wrap_a3", wlog[3], 3);
      check_eq("wrap_a4", wlog[4], 8);
    end

    // Simultaneous results are written in round-robin order.
    cyc('0, 1'b1);
    wlog.delete();
    cyc(2'b11, 1'b0);
    idle(3);
    cyc(2'b11, 1'b0);
    idle(4);
    check_eq("rr_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check_eq("rr_a0", wlog[0], 0);
      check_eq("rr_a1", wlog[1], 4);
      check_eq("rr_a2", wlog[2], 1);
      check_eq("rr_a3", wlog[3], 5);
    end

    // Backpressure: hold, buffer, drop.
    cyc('0, 1'b1);
    wr_ready = 1'b0;
    cyc(2'b01, 1'b0);
    cyc('0, 1'b0);
    cyc(2'b01, 1'b0);
    cyc('0, 1'b0);
    cyc(2'b01, 1'b0);
    idle(7);
    check_eq("bp_overflow", overflow, 1);
    check_eq("bp_held_addr", wr_addr, 0);
`ifdef PIXEL_COLLECTOR_STATS_EN
    check_eq("bp_stalls", stall_cycles, 10);
`else
    check_eq("bp_stalls", stall_cycles, 0);
`endif
    wr_ready = 1'b1;
    idle(4);

    // Full frame, then a restart mid-frame.
    cyc('0, 1'b1);
    wlog.delete();
    for (int i = 0; i < TOTAL / N; i++) begin
      cyc(2'b11, 1'b0);
      cyc('0, 1'b0);
    end
    idle(4);
    check_eq("frame_pixels", wlog.size(), TOTAL);
    check_eq("frame_done_end", frame_done, 1);
    check_eq("busy_end", busy, 0);
    cyc('0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 1'b0);
      cyc('0, 1'b0);
    end
    idle(2);
    cyc('0, 1'b1);
    wlog.delete();
    cyc(2'b01, 1'b0);
    idle(3);
    check_eq("restart_count", wlog.size(), 1);
    if (wlog.size() == 1) check_eq("restart_addr", wlog[0], 0);

    // Random traffic with occasional start and reset.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rdy;
      for (int k = 0; k < N; k++) rdy[k] = ($urandom_range(0, 2) == 0);
      wr_ready = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 499) == 0);
      cyc(rdy, $urandom_range(0, 149) == 0);
    end
    reset = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
